accel_run_sequencer: RTL and testbench
======================================

Name: accel_run_sequencer

Overview:
Hardware run controller for an HLS-generated `main` accelerator.
- Preloads a block of words into the accelerator's internal memory through its slave RAM port.
- Pulses `start_port`, then counts cycles until `done_port`, with a watchdog.
- Reads a result block back out through the same slave port.
- Sits between a host/DMA stream and the accelerator; it replaces the file-driven simulation harness in hardware bring-up.

Parameters:
ADDR_W, 10, per-channel slave address width (bytes)
DATA_W, 64, per-channel slave data width
SIZE_W, 7, per-channel data_ram_size width
XFER_BITS, 32, access size driven on S_data_ram_size
WORD_BYTES, 4, address increment per word
CNT_W, 32, cycle counter width
TIMEOUT, 200000000, maximum RUN cycles before abort

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; all state to IDLE
cmd_valid  in  1  run request
cmd_ready  out  1  high only in IDLE
cmd_base  in  ADDR_W  start byte address, shared by load and readback
cmd_load_len  in  16  words to preload
cmd_read_len  in  16  words to read back
load_valid  in  1  preload word available
load_ready  out  1  preload word consumed
load_data  in  32  preload word
res_valid  out  1  result word valid
res_ready  in  1  result consumer ready
res_data  out  32  result word
start_port  out  1  accelerator start pulse
done_port  in  1  accelerator done
S_oe_ram  out  2  slave read enable; bit1 tied 0
S_we_ram  out  2  slave write enable; bit1 tied 0
S_addr_ram  out  2*ADDR_W  slave address; upper channel 0
S_Wdata_ram  out  2*DATA_W  slave write data; zero-extended word
S_data_ram_size  out  2*SIZE_W  XFER_BITS on channel 0 during an access, else 0
Sout_Rdata_ram  in  2*DATA_W  slave read data; bits [31:0] used
Sout_DataRdy  in  2  slave access complete; bit0 used
run_done  out  1  one-cycle pulse at end of run
status  out  2  00 idle, 01 ok, 10 timeout; held until next command accepted
cycles  out  CNT_W  RUN cycle count, held until next command

Behaviour:
Reset values: every output 0, status=00, cycles=0.
All outputs are registered except cmd_ready and load_ready.

States: IDLE, LOAD, START, RUN, READ, OUT, FIN.
- IDLE:
  - On cmd_valid, latch base/lengths; addr<=cmd_base; status<=00; cycles<=0.
  - Next state: LOAD if load_len>0; else START.
- LOAD:
  - When load_valid and no access is pending, drive we[0]=1 with addr/data/size.
  - Hold all slave signals until Sout_DataRdy[0]=1.
  - In that DataRdy cycle: load_ready=1 (combinational), we[0]<=0, addr+=WORD_BYTES, remaining-1.
  - After the last word, go to START.
  - A DataRdy arriving in the same cycle the request is first driven is not valid; DataRdy is ignored when no access is pending.
- START:
  - start_port=1 for exactly one cycle; counter<=0; go to RUN.
- RUN:
  - Each cycle, counter+1.
  - If done_port=1: cycles<=counter+1 (done in the first RUN cycle gives 1); status<=01.
    - Then addr<=base; go to READ if read_len>0, else FIN.
  - Else if counter+1==TIMEOUT: cycles<=TIMEOUT; status<=10; go to FIN (no readback).
  - done_port outside RUN is ignored.
- READ:
  - Drive oe[0]=1 with addr/size until DataRdy[0].
  - On DataRdy: capture Rdata[31:0] into res_data; res_valid<=1; oe<=0; go to OUT.
- OUT:
  - Hold res_valid/res_data stable until res_ready.
  - On handshake: addr+=WORD_BYTES, remaining-1; go to READ, or FIN after the last word.
- FIN:
  - run_done=1 for one cycle; go to IDLE.

Rules:
- Addresses wrap modulo 2^ADDR_W.
- oe and we are never both high.
- A command presented while busy waits, because cmd_ready=0.
- Reset mid-operation aborts immediately: the slave access is dropped and start_port is forced to 0.

Test Plan:
- load_len=3 (0x11,0x22,0x33), base=0x040, read_len=2; slave DataRdy after 2 cycles; done 10 cycles after start -> writes at 0x040/0x044/0x048; start_port pulse width 1; cycles=10; status=01; res 0x11,0x22; run_done once.
- load_len=0, read_len=0, done in first RUN cycle -> no slave access; cycles=1; status=01; FIN within 3 cycles of START.
- TIMEOUT=16, done never -> cycles=16; status=10; no oe asserted; run_done pulse.
- res_ready low 5 cycles during readback -> res_data stable; no second oe until handshake; 4 words delivered in order.
- Reset asserted while we[0]=1 mid-load -> next cycle all outputs 0, state IDLE, cmd_ready=1; a new command runs normally.
- base=0x3FC, load_len=2 -> second write at address 0x000 (wrap).

Source files
------------

// File: rtl/accel_run_sequencer.sv
// accel_run_sequencer: bring-up run controller for an HLS "main" accelerator.
// Preloads words through the accelerator's slave RAM port, pulses start,
// times the run (with a watchdog), then streams a result block back out.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A source holds valid and its data stable until that edge.
// cmd_ready and load_ready are combinational; everything else is registered.
module accel_run_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 64,
  parameter int SIZE_W     = 7,
  parameter int XFER_BITS  = 32,
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_base,
  input  logic [15:0]           cmd_load_len,
  input  logic [15:0]           cmd_read_len,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [31:0]           load_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_data,
  output logic                  start_port,
  input  logic                  done_port,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy,
  output logic                  run_done,
  output logic [1:0]            status,
  output logic [CNT_W-1:0]      cycles,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    READ  = 3'd4,
    OUT   = 3'd5,
    FIN   = 3'd6
  } state_t;

  localparam logic [SIZE_W-1:0] XFER = SIZE_W'(XFER_BITS);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);
  localparam logic [CNT_W-1:0]  TMO  = CNT_W'(TIMEOUT);

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   addr;
  logic [15:0]         load_rem;
  logic [15:0]         read_rem;
  logic                pending;   // a slave access is on the bus awaiting DataRdy
  logic                oe0;
  logic                we0;
  logic [31:0]         wdata;
  logic [SIZE_W-1:0]   size_q;
  logic [CNT_W-1:0]    counter;
  logic [CNT_W-1:0]    cnt_inc;
  logic                rdy0;

  assign rdy0    = Sout_DataRdy[0];
  assign cnt_inc = counter + CNT_W'(1);

  // Only channel 0 of the dual-channel slave port is used.
  assign S_oe_ram        = {1'b0, oe0};
  assign S_we_ram        = {1'b0, we0};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, addr};
  assign S_Wdata_ram     = {{(2*DATA_W-32){1'b0}}, wdata};
  assign S_data_ram_size = {{SIZE_W{1'b0}}, size_q};

  assign cmd_ready  = (state == IDLE);
  assign load_ready = (state == LOAD) && pending && rdy0;
  assign dbg_state  = state;

  logic unused_inputs;
  assign unused_inputs = ^{Sout_Rdata_ram[2*DATA_W-1:32], Sout_DataRdy[1]};

  // Run sequencer: command latch, preload writes, start/run timing, readback.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      base_q     <= '0;
      addr       <= '0;
      load_rem   <= '0;
      read_rem   <= '0;
      pending    <= 1'b0;
      oe0        <= 1'b0;
      we0        <= 1'b0;
      wdata      <= '0;
      size_q     <= '0;
      counter    <= '0;
      cycles     <= '0;
      status     <= 2'b00;
      start_port <= 1'b0;
      run_done   <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
    end else begin
      start_port <= 1'b0;
      run_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            base_q   <= cmd_base;
            addr     <= cmd_base;
            load_rem <= cmd_load_len;
            read_rem <= cmd_read_len;
            status   <= 2'b00;
            cycles   <= '0;
            if (cmd_load_len != 16'd0) begin
              state <= LOAD;
            end else begin
              state      <= START;
              start_port <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (!pending) begin
            if (load_valid) begin
              we0     <= 1'b1;
              wdata   <= load_data;
              size_q  <= XFER;
              pending <= 1'b1;
            end
          end else if (rdy0) begin
            we0      <= 1'b0;
            size_q   <= '0;
            pending  <= 1'b0;
            addr     <= addr + STEP;
            load_rem <= load_rem - 16'd1;
            if (load_rem == 16'd1) begin
              state      <= START;
              start_port <= 1'b1;
            end
          end
        end
        START: begin
          counter <= '0;
          state   <= RUN;
        end
        RUN: begin
          counter <= cnt_inc;
          if (done_port) begin
            cycles <= cnt_inc;
            status <= 2'b01;
            addr   <= base_q;
            if (read_rem != 16'd0) begin
              state   <= READ;
              oe0     <= 1'b1;
              size_q  <= XFER;
              pending <= 1'b1;
            end else begin
              state    <= FIN;
              run_done <= 1'b1;
            end
          end else if (cnt_inc == TMO) begin
            cycles   <= TMO;
            status   <= 2'b10;
            state    <= FIN;
            run_done <= 1'b1;
          end
        end
        READ: begin
          if (pending && rdy0) begin
            res_data  <= Sout_Rdata_ram[31:0];
            res_valid <= 1'b1;
            oe0       <= 1'b0;
            size_q    <= '0;
            pending   <= 1'b0;
            state     <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            addr      <= addr + STEP;
            read_rem  <= read_rem - 16'd1;
            if (read_rem == 16'd1) begin
              state    <= FIN;
              run_done <= 1'b1;
            end else begin
              state   <= READ;
              oe0     <= 1'b1;
              size_q  <= XFER;
              pending <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_run_sequencer.sv
// Bench for accel_run_sequencer: table of whole-run vectors plus hand-written
// reset-abort sequence. A latency-2 slave RAM model sits on the slave port.
module tb_accel_run_sequencer;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int SIZE_W = 7;
  localparam int CNT_W  = 32;
  localparam int TMO    = 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_base = '0;
  logic [15:0]           cmd_load_len = '0;
  logic [15:0]           cmd_read_len = '0;
  logic                  load_valid = 1'b0;
  logic                  load_ready;
  logic [31:0]           load_data = '0;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic [31:0]           res_data;
  logic                  start_port;
  logic                  done_port = 1'b0;
  logic [1:0]            S_oe_ram;
  logic [1:0]            S_we_ram;
  logic [2*ADDR_W-1:0]   S_addr_ram;
  logic [2*DATA_W-1:0]   S_Wdata_ram;
  logic [2*SIZE_W-1:0]   S_data_ram_size;
  logic [2*DATA_W-1:0]   Sout_Rdata_ram;
  logic [1:0]            Sout_DataRdy;
  logic                  run_done;
  logic [1:0]            status;
  logic [CNT_W-1:0]      cycles;
  logic [2:0]            dbg_state;

  accel_run_sequencer #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .cmd_load_len(cmd_load_len), .cmd_read_len(cmd_read_len),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .start_port(start_port), .done_port(done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .run_done(run_done), .status(status), .cycles(cycles), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // slave RAM model: DataRdy on the 3rd cycle an access is visible
  logic [31:0] slave_mem [0:255];
  logic [31:0] ref_mem   [0:255];
  logic        rdy = 1'b0;
  logic [31:0] rd_word = '0;
  int          lat_cnt = 0;

  assign Sout_Rdata_ram = {64'hFFFF_0000_FFFF_0000, 32'hDEAD_BEEF, rd_word};
  assign Sout_DataRdy   = {1'b1, rdy};

  initial begin
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 32'hA000_0000 | 32'(i);
      ref_mem[i]   = 32'hA000_0000 | 32'(i);
    end
    forever begin
      @(posedge clock);
      if (reset || (!S_we_ram[0] && !S_oe_ram[0])) begin
        rdy     <= 1'b0;
        lat_cnt <= 0;
      end else if (rdy) begin
        rdy     <= 1'b0;
        lat_cnt <= 0;
        if (S_we_ram[0]) slave_mem[S_addr_ram[9:2]] <= S_Wdata_ram[31:0];
      end else if (lat_cnt == 1) begin
        rdy     <= 1'b1;
        rd_word <= slave_mem[S_addr_ram[9:2]];
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  // bus monitor: event counters and completed writes
  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
    logic [6:0]  sz;
  } wr_t;
  wr_t obs_wr_q[$];
  int start_cnt = 0, done_cnt = 0, oe_cnt = 0, we_cnt = 0, both_cnt = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (start_port) start_cnt++;
      if (run_done) done_cnt++;
      if (S_oe_ram[0]) oe_cnt++;
      if (S_we_ram[0]) we_cnt++;
      if (S_oe_ram[0] && S_we_ram[0]) both_cnt++;
      if (S_we_ram[0] && rdy)
        obs_wr_q.push_back('{a: S_addr_ram[9:0], d: S_Wdata_ram[31:0], sz: S_data_ram_size[6:0]});
    end
  end

  // scoreboard
  logic [31:0] exp_q[$];

  typedef struct {
    logic [9:0]  base;
    int          load_len;
    int          read_len;
    int          done_after;   // RUN cycle in which done is seen; 0 = never
    bit          stall;        // hold res_ready low 5 cycles on word 1
    logic [31:0] exp_cycles;
    logic [1:0]  exp_status;
    int          exp_fin;      // negedges from START to FIN (read_len == 0 only)
  } vec_t;

  vec_t vecs[6];

  // driver: one complete run described by a vector
  task automatic run_vec(input vec_t v, input string tag);
    int s_start, s_done, s_oe, s_we, s_both, wr_base, k, fin_at, oe_before;
    logic [9:0]  a;
    logic [31:0] d;
    logic [31:0] held;
    bit          stable;
    wr_t         wexp[$];
    wr_t         got;
    s_start = start_cnt; s_done = done_cnt; s_oe = oe_cnt;
    s_we = we_cnt; s_both = both_cnt; wr_base = obs_wr_q.size();
    for (int i = 0; i < v.load_len; i++) begin
      a = v.base + 10'(4 * i);
      d = 32'h11 * 32'(i + 1);
      wexp.push_back('{a: a, d: d, sz: 7'd32});
      ref_mem[a[9:2]] = d;
    end
    for (int j = 0; j < v.read_len; j++) begin
      a = v.base + 10'(4 * j);
      exp_q.push_back(ref_mem[a[9:2]]);
    end

    cmd_base = v.base; cmd_load_len = 16'(v.load_len); cmd_read_len = 16'(v.read_len);
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clock); k++; end
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
    check({tag, "_status_cleared"}, {30'd0, status, cycles}, 64'd0);

    for (int i = 0; i < v.load_len; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h11 * 32'(i + 1);
      k = 0;
      while (!load_ready && k < 50) begin @(negedge clock); k++; end
      check({tag, "_load_ready"}, 64'(load_ready), 64'd1);
      @(negedge clock);
    end
    load_valid = 1'b0;

    k = 0;
    while (!start_port && k < 100) begin @(negedge clock); k++; end
    check({tag, "_start_seen"}, 64'(start_port), 64'd1);
    check({tag, "_busy_cmd_ready"}, 64'(cmd_ready), 64'd0);

    if (v.read_len == 0) begin
      fin_at = 0;
      for (int t = 1; t <= 60 && fin_at == 0; t++) begin
        @(negedge clock);
        if (run_done) fin_at = t;
        done_port = (t == v.done_after);
      end
      done_port = 1'b0;
      check({tag, "_fin_latency"}, 64'(fin_at), 64'(v.exp_fin));
    end else begin
      repeat (v.done_after) @(negedge clock);
      done_port = 1'b1;
      @(negedge clock);
      done_port = 1'b0;
      for (int j = 0; j < v.read_len; j++) begin
        k = 0;
        while (!res_valid && k < 40) begin @(negedge clock); k++; end
        check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
        if (v.stall && j == 1) begin
          held = res_data; oe_before = oe_cnt; stable = 1'b1;
          repeat (5) begin
            @(negedge clock);
            if (res_data !== held || !res_valid) stable = 1'b0;
          end
          check({tag, "_stall_stable"}, 64'(stable), 64'd1);
          check({tag, "_stall_no_oe"}, 64'(oe_cnt - oe_before), 64'd0);
        end
        res_ready = 1'b1;
        check({tag, "_res_data"}, 64'(res_data), 64'(exp_q.pop_front()));
        @(negedge clock);
        res_ready = 1'b0;
      end
      k = 0;
      while (!run_done && k < 40) begin @(negedge clock); k++; end
      check({tag, "_run_done_seen"}, 64'(run_done), 64'd1);
    end

    repeat (2) @(negedge clock);
    check({tag, "_cycles"}, 64'(cycles), 64'(v.exp_cycles));
    check({tag, "_status"}, 64'(status), 64'(v.exp_status));
    check({tag, "_start_pulses"}, 64'(start_cnt - s_start), 64'd1);
    check({tag, "_run_done_pulses"}, 64'(done_cnt - s_done), 64'd1);
    check({tag, "_oe_we_overlap"}, 64'(both_cnt - s_both), 64'd0);
    check({tag, "_write_count"}, 64'(obs_wr_q.size() - wr_base), 64'(v.load_len));
    for (int i = 0; i < wexp.size() && wr_base + i < obs_wr_q.size(); i++) begin
      got = obs_wr_q[wr_base + i];
      check({tag, "_write"}, 64'(got), 64'(wexp[i]));
    end
    if (v.read_len == 0) check({tag, "_no_oe"}, 64'(oe_cnt - s_oe), 64'd0);
    if (v.load_len == 0) check({tag, "_no_we"}, 64'(we_cnt - s_we), 64'd0);
    check({tag, "_back_idle"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl_outs"},
          64'({res_valid, start_port, S_oe_ram, S_we_ram, run_done, status, load_ready}), 64'd0);
    check({tag, "_bus_outs"},
          64'({S_addr_ram, S_data_ram_size} | 34'(S_Wdata_ram != '0)), 64'd0);
    check({tag, "_res_data"}, 64'(res_data), 64'd0);
    check({tag, "_cycles"}, 64'(cycles), 64'd0);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    int k;
    //          base    ld rd done stall cycles status fin
    vecs[0] = '{10'h040, 3, 2, 10, 1'b0, 32'd10, 2'b01, 0};
    vecs[1] = '{10'h100, 0, 0,  1, 1'b0, 32'd1,  2'b01, 2};
    vecs[2] = '{10'h200, 1, 0,  0, 1'b0, 32'd16, 2'b10, 17};
    vecs[3] = '{10'h080, 4, 4,  3, 1'b1, 32'd3,  2'b01, 0};
    vecs[4] = '{10'h3FC, 2, 2,  5, 1'b0, 32'd5,  2'b01, 0};
    vecs[5] = '{10'h0C0, 0, 2, 16, 1'b0, 32'd16, 2'b01, 0};

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // reset while a preload write is on the bus
    cmd_base = 10'h010; cmd_load_len = 16'd2; cmd_read_len = 16'd1;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'h5555_5555;
    k = 0;
    while (!S_we_ram[0] && k < 20) begin @(negedge clock); k++; end
    check("abort_we_seen", 64'(S_we_ram[0]), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    load_valid = 1'b0;
    check_all_zero("abort");
    @(negedge clock);
    run_vec(vecs[0], "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
